// File: rtl/eth_pcs_66_64_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pcs_66_64_dec_pkg
// Description : Widths, 64b/66b block codes, XGMII symbols and FSM encodings
//               shared by the receive-side 64b/66b decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pcs_66_64_dec_pkg;

    localparam int N_CHANNELS      = 4;
    localparam int W_BYTE          = 8;
    localparam int W_DATA          = 32;
    localparam int W_SYNC          = 2;
    localparam int N_TRANS_PER_BLK = 2;
    localparam int N_BYTES_PER_BLK = 8;
    localparam int W_TRANS_PER_BLK = $clog2(N_TRANS_PER_BLK);
    localparam int W_BLK           = N_BYTES_PER_BLK * W_BYTE;
    localparam int W_CODE          = 7;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] C_TYPE  = 8'h1E;
    localparam logic [7:0] S0_TYPE = 8'h78;
    localparam logic [7:0] S4_TYPE = 8'h33;
    localparam logic [7:0] T0_TYPE = 8'h87;
    localparam logic [7:0] T1_TYPE = 8'h99;
    localparam logic [7:0] T2_TYPE = 8'hAA;
    localparam logic [7:0] T3_TYPE = 8'hB4;
    localparam logic [7:0] T4_TYPE = 8'hCC;
    localparam logic [7:0] T5_TYPE = 8'hD2;
    localparam logic [7:0] T6_TYPE = 8'hE1;
    localparam logic [7:0] T7_TYPE = 8'hFF;

    localparam logic [W_CODE-1:0] CODE_IDLE = 7'h00;
    localparam logic [W_CODE-1:0] CODE_ERR  = 7'h1E;

    localparam logic [W_BYTE-1:0] SYM_IDLE  = 8'h07;
    localparam logic [W_BYTE-1:0] SYM_ERR   = 8'hFE;
    localparam logic [W_BYTE-1:0] SYM_START = 8'hFB;
    localparam logic [W_BYTE-1:0] SYM_TERM  = 8'hFD;

    // Local-fault ordered set for one four-lane column
    localparam logic [N_CHANNELS-1:0] SEQ_LF_CTRL = 4'b0001;
    localparam logic [W_DATA-1:0]     SEQ_LF_DATA = 32'h0100_009C;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_INIT = 3'd0;
    localparam rx_state_t RX_C    = 3'd1;
    localparam rx_state_t RX_D    = 3'd2;
    localparam rx_state_t RX_T    = 3'd3;
    localparam rx_state_t RX_E    = 3'd4;

    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_T, BLK_D, BLK_E} blk_class_t;

    // Returns {valid, lane of the terminate character} for a block type byte
    function automatic logic [3:0] term_lane(input logic [7:0] blk_type);
        case (blk_type)
            T0_TYPE: term_lane = 4'b1_000;
            T1_TYPE: term_lane = 4'b1_001;
            T2_TYPE: term_lane = 4'b1_010;
            T3_TYPE: term_lane = 4'b1_011;
            T4_TYPE: term_lane = 4'b1_100;
            T5_TYPE: term_lane = 4'b1_101;
            T6_TYPE: term_lane = 4'b1_110;
            T7_TYPE: term_lane = 4'b1_111;
            default: term_lane = 4'b0_000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_pcs_66_64_dec_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_pcs_66_64_dec_if
// Description : Block-stream input and XGMII RX output bundle of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_pcs_66_64_dec_if;
    import eth_pcs_66_64_dec_pkg::*;

    logic                           i_clk_en;
    logic [W_TRANS_PER_BLK-1:0]     i_trans_cnt;
    logic                           i_blk_lock;
    logic [W_SYNC-1:0]              i_sync_data;
    logic [W_DATA-1:0]              i_pld_data;
    logic [N_CHANNELS-1:0]          o_xgmii_ctrl;
    logic [N_CHANNELS*W_BYTE-1:0]   o_xgmii_data;
    logic                           o_dec_err;

    modport master (
        output i_clk_en, i_trans_cnt, i_blk_lock, i_sync_data, i_pld_data,
        input  o_xgmii_ctrl, o_xgmii_data, o_dec_err
    );

    modport slave (
        input  i_clk_en, i_trans_cnt, i_blk_lock, i_sync_data, i_pld_data,
        output o_xgmii_ctrl, o_xgmii_data, o_dec_err
    );

endinterface
`default_nettype wire

// File: rtl/eth_pcs_66_64_dec_blk_dec.sv
`default_nettype none
// ============================================================================
// Module      : eth_pcs_66_64_blk_dec
// Description : Combinational classifier/decoder of one 66-bit block into
//               eight XGMII lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_pcs_66_64_blk_dec
    import eth_pcs_66_64_dec_pkg::*;
(
    input  logic [W_SYNC-1:0]          i_sync,
    input  logic [W_BLK-1:0]           i_pld,
    output blk_class_t                 o_cls,
    output logic [N_BYTES_PER_BLK-1:0] o_ctrl,
    output logic [W_BLK-1:0]           o_data
);

    logic [7:0]                 w_type;
    logic [N_BYTES_PER_BLK-1:0] w_code_idle;
    logic [N_BYTES_PER_BLK-1:0] w_code_ok;
    logic [3:0]                 w_term;
    logic                       w_trail_idle;
    logic [W_BLK-1:0]           w_dsh;

    assign w_type = i_pld[7:0];
    assign w_term = term_lane(w_type);
    // T blocks carry data byte j just above the type byte
    assign w_dsh  = {8'h00, i_pld[W_BLK-1:8]};

    // 7-bit lane code k sits at bit 8+7k in both C and T block formats
    always_comb begin
        w_code_idle  = '0;
        w_code_ok    = '0;
        w_trail_idle = 1'b1;
        for (int k = 0; k < N_BYTES_PER_BLK; k++) begin
            w_code_idle[k] = (i_pld[8+W_CODE*k +: W_CODE] == CODE_IDLE);
            w_code_ok[k]   = w_code_idle[k] || (i_pld[8+W_CODE*k +: W_CODE] == CODE_ERR);
            if ((k > int'(w_term[2:0])) && !w_code_idle[k])
                w_trail_idle = 1'b0;
        end
    end

    always_comb begin
        o_cls  = BLK_E;
        o_ctrl = '1;
        o_data = {N_BYTES_PER_BLK{SYM_ERR}};
        if (i_sync == SYNC_DATA) begin
            o_cls  = BLK_D;
            o_ctrl = '0;
            o_data = i_pld;
        end else if (i_sync == SYNC_CTRL) begin
            if ((w_type == C_TYPE) && (&w_code_ok)) begin
                o_cls = BLK_C;
                for (int k = 0; k < N_BYTES_PER_BLK; k++)
                    o_data[W_BYTE*k +: W_BYTE] = w_code_idle[k] ? SYM_IDLE : SYM_ERR;
            end else if (w_type == S0_TYPE) begin
                o_cls  = BLK_S;
                o_ctrl = 8'h01;
                o_data = {i_pld[W_BLK-1:8], SYM_START};
            end else if ((w_type == S4_TYPE) && (&w_code_idle[3:0])) begin
                o_cls  = BLK_S;
                o_ctrl = 8'h1F;
                o_data = {i_pld[W_BLK-1:40], SYM_START, {4{SYM_IDLE}}};
            end else if (w_term[3] && w_trail_idle) begin
                o_cls = BLK_T;
                for (int k = 0; k < N_BYTES_PER_BLK; k++) begin
                    if (k < int'(w_term[2:0])) begin
                        o_ctrl[k]                  = 1'b0;
                        o_data[W_BYTE*k +: W_BYTE] = w_dsh[W_BYTE*k +: W_BYTE];
                    end else if (k == int'(w_term[2:0])) begin
                        o_data[W_BYTE*k +: W_BYTE] = SYM_TERM;
                    end else begin
                        o_data[W_BYTE*k +: W_BYTE] = SYM_IDLE;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_pcs_66_64_dec.sv
`default_nettype none
// ============================================================================
// Module      : eth_pcs_66_64_dec
// Description : 64b/66b receive decoder: block capture, Clause 49 RX FSM and
//               per-transfer XGMII replay. Option: ETH_PCS_DEC_LF_EN emits
//               local fault instead of errors on block-lock loss.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_pcs_66_64_dec
    import eth_pcs_66_64_dec_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    eth_pcs_66_64_dec_if.slave dec_if
);

    localparam logic [W_TRANS_PER_BLK-1:0] c_last_trans = W_TRANS_PER_BLK'(N_TRANS_PER_BLK-1);
`ifdef ETH_PCS_DEC_LF_EN
    localparam logic [N_BYTES_PER_BLK-1:0] c_ll_ctrl = {N_TRANS_PER_BLK{SEQ_LF_CTRL}};
    localparam logic [W_BLK-1:0]           c_ll_data = {N_TRANS_PER_BLK{SEQ_LF_DATA}};
`else
    localparam logic [N_BYTES_PER_BLK-1:0] c_ll_ctrl = '1;
    localparam logic [W_BLK-1:0]           c_ll_data = {N_BYTES_PER_BLK{SYM_ERR}};
`endif

    logic [W_SYNC-1:0]                                 r_sync;
    logic [N_TRANS_PER_BLK-2:0][W_DATA-1:0]            r_pld;
    rx_state_t                                         r_state;
    logic [N_TRANS_PER_BLK-1:0][N_CHANNELS-1:0]        r_out_ctrl;
    logic [N_TRANS_PER_BLK-1:0][N_CHANNELS*W_BYTE-1:0] r_out_data;
    logic                                              r_dec_err;

    logic [W_BLK-1:0]           w_pld;
    logic                       w_decode;
    blk_class_t                 w_cls;
    logic [N_BYTES_PER_BLK-1:0] w_blk_ctrl;
    logic [W_BLK-1:0]           w_blk_data;
    rx_state_t                  w_next_state;

    // The last slice is decoded straight from the input without being stored
    assign w_pld    = {dec_if.i_pld_data, r_pld};
    assign w_decode = dec_if.i_clk_en && (dec_if.i_trans_cnt == c_last_trans);

    eth_pcs_66_64_blk_dec u_blk_dec (
        .i_sync (r_sync),
        .i_pld  (w_pld),
        .o_cls  (w_cls),
        .o_ctrl (w_blk_ctrl),
        .o_data (w_blk_data)
    );

    always_comb begin
        w_next_state = RX_E;
        case (r_state)
            RX_INIT, RX_C, RX_T: begin
                if (w_cls == BLK_C)      w_next_state = RX_C;
                else if (w_cls == BLK_S) w_next_state = RX_D;
            end
            RX_D: begin
                if (w_cls == BLK_D)      w_next_state = RX_D;
                else if (w_cls == BLK_T) w_next_state = RX_T;
            end
            default: begin
                if (w_cls == BLK_C)      w_next_state = RX_C;
                else if (w_cls == BLK_D) w_next_state = RX_D;
                else if (w_cls == BLK_T) w_next_state = RX_T;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= RX_INIT;
            r_sync     <= '0;
            r_pld      <= '0;
            r_out_ctrl <= '1;
            r_out_data <= {N_BYTES_PER_BLK{SYM_IDLE}};
            r_dec_err  <= 1'b0;
        end else if (dec_if.i_clk_en) begin
            if (dec_if.i_trans_cnt == '0)
                r_sync <= dec_if.i_sync_data;
            for (int s = 0; s < N_TRANS_PER_BLK-1; s++)
                if (dec_if.i_trans_cnt == W_TRANS_PER_BLK'(s))
                    r_pld[s] <= dec_if.i_pld_data;
            if (w_decode) begin
                if (!dec_if.i_blk_lock) begin
                    r_state    <= RX_INIT;
                    r_out_ctrl <= c_ll_ctrl;
                    r_out_data <= c_ll_data;
                    r_dec_err  <= 1'b0;
                end else begin
                    r_state <= w_next_state;
                    if (w_next_state == RX_E) begin
                        r_out_ctrl <= '1;
                        r_out_data <= {N_BYTES_PER_BLK{SYM_ERR}};
                        r_dec_err  <= 1'b1;
                    end else begin
                        r_out_ctrl <= w_blk_ctrl;
                        r_out_data <= w_blk_data;
                        r_dec_err  <= 1'b0;
                    end
                end
            end
        end
    end

    assign dec_if.o_xgmii_ctrl = r_out_ctrl[dec_if.i_trans_cnt];
    assign dec_if.o_xgmii_data = r_out_data[dec_if.i_trans_cnt];
    assign dec_if.o_dec_err    = r_dec_err;

endmodule
`default_nettype wire

// File: tb/tb_eth_pcs_66_64_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_pcs_66_64_dec
// Description : Self-checking bench: encodes random 64b/66b blocks from lane
//               values and checks the decoder against a table-driven model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_pcs_66_64_dec;

    typedef enum int {M_INIT, M_C, M_D, M_T, M_E} mstate_t;
    typedef enum int {K_C, K_S, K_T, K_D, K_E} kcls_t;
    localparam int G_C = 0, G_CBAD = 1, G_S0 = 2, G_S4 = 3, G_S4BAD = 4,
                   G_T = 5, G_TBAD = 6, G_D = 7, G_BADSYNC = 8, G_BADTYPE = 9;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 i_clk = ~i_clk;

    eth_pcs_66_64_dec_if u_if();

    eth_pcs_66_64_dec u_dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .dec_if  (u_if)
    );

    // Reference model: expected registered block and receive state
    mstate_t    m_st;
    logic [7:0] m_d [8];
    logic       m_c [8];
    logic       m_err;
    mstate_t    nxt [5][5];
    logic [7:0] t_types [8];

    // Block produced by the encoder
    logic [1:0]  g_sync;
    logic [63:0] g_pld;
    kcls_t       g_cls;
    logic [7:0]  g_d [8];
    logic        g_c [8];
    logic [0:0]  last_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_slot(input int s);
        logic [3:0]  ec;
        logic [31:0] ed;
        for (int l = 0; l < 4; l++) begin
            ec[l]          = m_c[4*s+l];
            ed[8*l +: 8]   = m_d[4*s+l];
        end
        check($sformatf("ctrl slot%0d", s), 64'(u_if.o_xgmii_ctrl), 64'(ec));
        check($sformatf("data slot%0d", s), 64'(u_if.o_xgmii_data), 64'(ed));
        check("dec_err", 64'(u_if.o_dec_err), 64'(m_err));
    endtask

    task automatic fill_lanes(input logic c, input logic [7:0] d);
        for (int l = 0; l < 8; l++) begin
            m_c[l] = c;
            m_d[l] = d;
        end
    endtask

    function automatic bit is_valid_type(input logic [7:0] t);
        bit v = (t == 8'h1E) || (t == 8'h78) || (t == 8'h33);
        for (int i = 0; i < 8; i++)
            if (t_types[i] == t) v = 1'b1;
        return v;
    endfunction

    task automatic model_decode(input logic lock);
        if (!lock) begin
            m_st  = M_INIT;
            m_err = 1'b0;
`ifdef ETH_PCS_DEC_LF_EN
            for (int l = 0; l < 8; l++) begin
                m_c[l] = (l % 4 == 0);
                m_d[l] = (l % 4 == 0) ? 8'h9C : (l % 4 == 3) ? 8'h01 : 8'h00;
            end
`else
            fill_lanes(1'b1, 8'hFE);
`endif
        end else begin
            m_st = nxt[int'(m_st)][int'(g_cls)];
            if (m_st == M_E) begin
                fill_lanes(1'b1, 8'hFE);
                m_err = 1'b1;
            end else begin
                for (int l = 0; l < 8; l++) begin
                    m_c[l] = g_c[l];
                    m_d[l] = g_d[l];
                end
                m_err = 1'b0;
            end
        end
    endtask

    // Encode a block of the given kind; rnd supplies the lane contents
    task automatic gen(input int kind, input logic [63:0] rnd);
        int         n;
        int         bl;
        logic [6:0] code;
        logic [7:0] t;
        g_sync = 2'b10;
        g_pld  = '0;
        g_cls  = K_E;
        for (int l = 0; l < 8; l++) begin
            g_c[l] = 1'b1;
            g_d[l] = 8'h07;
        end
        case (kind)
            G_C, G_CBAD: begin
                g_cls       = K_C;
                g_pld[7:0]  = 8'h1E;
                for (int l = 0; l < 8; l++) begin
                    if (rnd[l]) begin
                        g_pld[8+7*l +: 7] = 7'h1E;
                        g_d[l]            = 8'hFE;
                    end
                end
                if (kind == G_CBAD) begin
                    bl   = $urandom_range(0, 7);
                    code = 7'($urandom_range(1, 127));
                    if (code == 7'h1E) code = 7'h1F;
                    g_pld[8+7*bl +: 7] = code;
                    g_cls = K_E;
                end
            end
            G_S0: begin
                g_cls  = K_S;
                g_pld  = {rnd[63:8], 8'h78};
                g_d[0] = 8'hFB;
                for (int l = 1; l < 8; l++) begin
                    g_c[l] = 1'b0;
                    g_d[l] = rnd[8*l +: 8];
                end
            end
            G_S4, G_S4BAD: begin
                g_cls          = K_S;
                g_pld[7:0]     = 8'h33;
                g_pld[39:36]   = rnd[35:32];
                g_pld[63:40]   = rnd[63:40];
                g_d[4]         = 8'hFB;
                for (int l = 5; l < 8; l++) begin
                    g_c[l] = 1'b0;
                    g_d[l] = rnd[8*l +: 8];
                end
                if (kind == G_S4BAD) begin
                    bl = $urandom_range(0, 3);
                    g_pld[8+7*bl +: 7] = 7'($urandom_range(1, 127));
                    g_cls = K_E;
                end
            end
            G_T, G_TBAD: begin
                n = int'(rnd[58:56]);
                if (kind == G_TBAD && n == 7) n = $urandom_range(0, 6);
                g_cls      = K_T;
                g_pld[7:0] = t_types[n];
                for (int j = 0; j < n; j++) begin
                    g_pld[8+8*j +: 8] = rnd[8*j +: 8];
                    g_c[j]            = 1'b0;
                    g_d[j]            = rnd[8*j +: 8];
                end
                g_d[n] = 8'hFD;
                for (int b = 0; b < 7 - n; b++)
                    g_pld[8+8*n+b] = 1'($urandom);
                if (kind == G_TBAD) begin
                    bl = $urandom_range(n + 1, 7);
                    g_pld[8+7*bl +: 7] = 7'($urandom_range(1, 127));
                    g_cls = K_E;
                end
            end
            G_D: begin
                g_cls  = K_D;
                g_sync = 2'b01;
                g_pld  = rnd;
                for (int l = 0; l < 8; l++) begin
                    g_c[l] = 1'b0;
                    g_d[l] = rnd[8*l +: 8];
                end
            end
            G_BADSYNC: begin
                g_sync = rnd[0] ? 2'b11 : 2'b00;
                g_pld  = rnd;
            end
            default: begin
                t = rnd[7:0];
                while (is_valid_type(t)) t = t + 8'd1;
                g_pld = {rnd[63:8], t};
            end
        endcase
    endtask

    // One clock: drive, check the current slot mid-cycle, advance the model
    task automatic cycle(input logic en, input logic [0:0] cnt, input logic [1:0] sync,
                         input logic [31:0] pld, input logic lock);
        u_if.i_clk_en    = en;
        u_if.i_trans_cnt = cnt;
        u_if.i_sync_data = sync;
        u_if.i_pld_data  = pld;
        u_if.i_blk_lock  = lock;
        last_cnt         = cnt;
        @(negedge i_clk);
        chk_slot(int'(cnt));
        @(posedge i_clk);
        if (en && cnt == 1'b1) model_decode(lock);
        #1;
    endtask

    task automatic stall_cycles(input bit stall);
        if (stall)
            repeat ($urandom_range(0, 2))
                cycle(1'b0, last_cnt, 2'($urandom), $urandom, 1'($urandom));
    endtask

    task automatic send_block(input int kind, input logic [63:0] rnd, input logic lock, input bit stall);
        gen(kind, rnd);
        stall_cycles(stall);
        cycle(1'b1, 1'b0, g_sync, g_pld[31:0], 1'($urandom));
        stall_cycles(stall);
        cycle(1'b1, 1'b1, 2'($urandom), g_pld[63:32], lock);
    endtask

    task automatic do_reset();
        i_reset          = 1'b1;
        u_if.i_clk_en    = 1'b0;
        u_if.i_trans_cnt = 1'b1;
        last_cnt         = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        m_st    = M_INIT;
        m_err   = 1'b0;
        fill_lanes(1'b1, 8'h07);
        @(negedge i_clk);
        chk_slot(1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        t_types = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        //           C     S     T     D     E
        nxt = '{'{M_C, M_D, M_E, M_E, M_E},   // INIT
                '{M_C, M_D, M_E, M_E, M_E},   // C
                '{M_E, M_E, M_T, M_D, M_E},   // D
                '{M_C, M_D, M_E, M_E, M_E},   // T
                '{M_C, M_E, M_T, M_D, M_E}};  // E
        u_if.i_clk_en    = 1'b0;
        u_if.i_trans_cnt = 1'b1;
        u_if.i_blk_lock  = 1'b1;
        u_if.i_sync_data = 2'b00;
        u_if.i_pld_data  = '0;
        last_cnt         = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        // Directed sequences
        repeat (3) send_block(G_C, 64'h0, 1'b1, 1'b0);
        send_block(G_S0, 64'h0706_0504_0302_0100, 1'b1, 1'b0);
        send_block(G_T, 64'h07DD_CCBB_AA99_8877, 1'b1, 1'b0);
        send_block(G_C, 64'h0, 1'b1, 1'b0);
        send_block(G_D, 64'h1122_3344_5566_7788, 1'b1, 1'b0);
        send_block(G_C, 64'h0, 1'b1, 1'b0);
        send_block(G_S0, 64'hA1A2_A3A4_A5A6_A7A8, 1'b1, 1'b0);
        send_block(G_D, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        send_block(G_BADSYNC, 64'hFFFF_0000_FFFF_0001, 1'b1, 1'b0);
        send_block(G_D, 64'h0F0E_0D0C_0B0A_0908, 1'b1, 1'b0);
        send_block(G_BADTYPE, 64'h0000_0000_0000_0055, 1'b1, 1'b0);
        send_block(G_D, 64'h8877_6655_4433_2211, 1'b1, 1'b0);
        send_block(G_D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
        send_block(G_D, 64'h1357_9BDF_2468_ACE0, 1'b1, 1'b0);
        send_block(G_C, 64'h0, 1'b1, 1'b0);

        // Partial block then reset: the half-block must never surface
        gen(G_S0, 64'h0);
        cycle(1'b1, 1'b0, g_sync, g_pld[31:0], 1'b1);
        do_reset();
        send_block(G_D, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                gen(int'($urandom_range(0, 9)), {$urandom, $urandom});
                cycle(1'b1, 1'b0, g_sync, g_pld[31:0], 1'b1);
                do_reset();
            end
            send_block(int'($urandom_range(0, 9)), {$urandom, $urandom},
                       1'($urandom_range(0, 19) != 0), 1'b1);
        end

        // Flush the final block through both slots
        cycle(1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 2'b00, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
